// File: rtl/sync_pkg.sv
// Shared constants and helpers for the sync_edge_filter block: legal parameter ranges
// and a constant-foldable clog2 used to size the per-bit stability counters.
package sync_pkg;

   localparam int unsigned SYNC_STAGES_MIN   = 2;
   localparam int unsigned SYNC_STAGES_MAX   = 8;
   localparam int unsigned FILTER_CYCLES_MAX = 255;

   // Ceiling log2, never less than 1 so a counter always has at least one bit.
   function automatic int unsigned clog2_min1(input int unsigned v);
      int unsigned r;
      r = 0;
      for (int unsigned i = 0; i < 32; i++) begin
         if ((64'd1 << i) < 64'(v)) r = i + 1;
      end
      return (r == 0) ? 1 : r;
   endfunction

   function automatic bit stages_legal(input int unsigned s);
      return (s >= SYNC_STAGES_MIN) && (s <= SYNC_STAGES_MAX);
   endfunction

   function automatic bit filter_legal(input int unsigned f);
      return f <= FILTER_CYCLES_MAX;
   endfunction

endpackage

// File: rtl/sync_bit_filter.sv
// One synchronised bit: flop chain, stability counter, filtered output level and
// registered rise/fall pulses. change_o is the pre-register pulse so the parent can align to it.
module sync_bit_filter
   import sync_pkg::*;
#(
   parameter int unsigned SyncStages   = 2,
   parameter int unsigned FilterCycles = 0,
   parameter logic        ResetVal     = 1'b0
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic data_i,
   output logic data_o,
   output logic rise_o,
   output logic fall_o,
   output logic change_o
);

   localparam int unsigned CntW   = clog2_min1(FilterCycles + 1);
   localparam int unsigned Thresh = (FilterCycles > 1) ? FilterCycles : 1;

   (* ASYNC_REG = "TRUE" *) logic [SyncStages-1:0] sync_q;

   logic [CntW-1:0] cnt_q, cnt_d;
   logic            data_q, data_d;
   logic            rise_q, rise_d;
   logic            fall_q, fall_d;
   logic            mismatch;
   logic            hit;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sync_q <= {SyncStages{ResetVal}};
         cnt_q  <= '0;
         data_q <= ResetVal;
         rise_q <= 1'b0;
         fall_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SyncStages-2:0], data_i};
         cnt_q  <= cnt_d;
         data_q <= data_d;
         rise_q <= rise_d;
         fall_q <= fall_d;
      end
   end

   assign mismatch = sync_q[SyncStages-1] != data_q;
   assign hit      = (32'(cnt_q) + 32'd1) >= Thresh;

   always_comb begin
      cnt_d  = cnt_q;
      data_d = data_q;
      rise_d = 1'b0;
      fall_d = 1'b0;
      if (mismatch) begin
         if (hit) begin
            data_d = ~data_q;
            cnt_d  = '0;
            rise_d = ~data_q;
            fall_d = data_q;
         end else begin
            cnt_d = cnt_q + CntW'(1);
         end
      end else begin
         // Any matching sample breaks the run, so short glitches never accumulate.
         cnt_d = '0;
      end
   end

   assign data_o   = data_q;
   assign rise_o   = rise_q;
   assign fall_o   = fall_q;
   assign change_o = rise_d | fall_d;

endmodule

// File: rtl/sync_edge_filter.sv
// Multi-bit synchroniser with optional per-bit glitch filter and registered edge pulses,
// for quasi-static asynchronous control/status bits (not binary buses).
module sync_edge_filter
   import sync_pkg::*;
#(
   parameter int unsigned          DATA_WIDTH    = 4,
   parameter int unsigned          SYNC_STAGES   = 2,
   parameter int unsigned          FILTER_CYCLES = 0,
   parameter logic [DATA_WIDTH-1:0] RESET_VAL    = '0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] i_data,
   output logic [DATA_WIDTH-1:0] o_data,
   output logic [DATA_WIDTH-1:0] o_rise,
   output logic [DATA_WIDTH-1:0] o_fall,
   output logic                  o_changed
);

   if (!stages_legal(SYNC_STAGES)) begin : g_bad_stages
      $error("sync_edge_filter: SYNC_STAGES must be within 2..8");
   end
   if (!filter_legal(FILTER_CYCLES)) begin : g_bad_filter
      $error("sync_edge_filter: FILTER_CYCLES must not exceed 255");
   end

   logic [DATA_WIDTH-1:0] change;
   logic                  changed_q;

   for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_bit
      sync_bit_filter #(
         .SyncStages  (SYNC_STAGES),
         .FilterCycles(FILTER_CYCLES),
         .ResetVal    (RESET_VAL[i])
      ) u_bit (
         .clk_i   (clk),
         .rst_i   (rst),
         .data_i  (i_data[i]),
         .data_o  (o_data[i]),
         .rise_o  (o_rise[i]),
         .fall_o  (o_fall[i]),
         .change_o(change[i])
      );
   end

   // Registered from the per-bit next-state pulses so it lines up with o_rise/o_fall.
   always_ff @(posedge clk) begin
      if (rst) changed_q <= 1'b0;
      else     changed_q <= |change;
   end

   assign o_changed = changed_q;

endmodule

// File: tb/tb_sync_edge_filter.sv
// Directed bench for sync_edge_filter: several parameterisations side by side,
// each driven with hand-computed vectors and checked through one task.
module tb_sync_edge_filter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b, expected %b", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // d0: defaults; d1: S=3 F=4; d2: RESET_VAL=1111; d3: S=8; d4: F=2
   logic       rst0 = 1'b1, rst1 = 1'b1, rst2 = 1'b1, rst3 = 1'b1, rst4 = 1'b1;
   logic [3:0] i0 = '0, i1 = '0, i2 = '0, i3 = '0, i4 = '0;
   logic [3:0] d0, r0, f0, d1, r1, f1, d2, r2, f2, d3, r3, f3, d4, r4, f4;
   logic       c0, c1, c2, c3, c4;

   sync_edge_filter u_d0 (
      .clk(clk), .rst(rst0), .i_data(i0), .o_data(d0), .o_rise(r0), .o_fall(f0), .o_changed(c0)
   );
   sync_edge_filter #(.SYNC_STAGES(3), .FILTER_CYCLES(4)) u_d1 (
      .clk(clk), .rst(rst1), .i_data(i1), .o_data(d1), .o_rise(r1), .o_fall(f1), .o_changed(c1)
   );
   sync_edge_filter #(.RESET_VAL(4'b1111)) u_d2 (
      .clk(clk), .rst(rst2), .i_data(i2), .o_data(d2), .o_rise(r2), .o_fall(f2), .o_changed(c2)
   );
   sync_edge_filter #(.SYNC_STAGES(8)) u_d3 (
      .clk(clk), .rst(rst3), .i_data(i3), .o_data(d3), .o_rise(r3), .o_fall(f3), .o_changed(c3)
   );
   sync_edge_filter #(.FILTER_CYCLES(2)) u_d4 (
      .clk(clk), .rst(rst4), .i_data(i4), .o_data(d4), .o_rise(r4), .o_fall(f4), .o_changed(c4)
   );

   initial begin
      int rises, falls;
      logic prev_pulse, cur_pulse, last_was_rise, order_ok;

      step();
      step();
      // Reset state, all instances
      check("rst d0 data", 8'(d0), 8'h0);
      check("rst d0 rise", 8'(r0), 8'h0);
      check("rst d0 fall", 8'(f0), 8'h0);
      check("rst d0 chg", 8'(c0), 8'h0);
      check("rst d2 data", 8'(d2), 8'hf);
      check("rst d2 fall", 8'(f2), 8'h0);
      check("rst d2 chg", 8'(c2), 8'h0);
      rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0; rst3 = 1'b0; rst4 = 1'b0;

      // RESET_VAL=1111 with input held at 0: fall on every bit two edges after release
      step();
      check("rv r1 data", 8'(d2), 8'hf);
      step();
      check("rv r2 data", 8'(d2), 8'hf);
      check("rv r2 fall", 8'(f2), 8'h0);
      step();
      check("rv r3 data", 8'(d2), 8'h0);
      check("rv r3 fall", 8'(f2), 8'hf);
      check("rv r3 rise", 8'(r2), 8'h0);
      check("rv r3 chg", 8'(c2), 8'h1);
      step();
      check("rv r4 fall", 8'(f2), 8'h0);
      check("rv r4 chg", 8'(c2), 8'h0);

      // Defaults: 0101 appears two edges after capture with one-cycle pulses
      i0 = 4'b0101;
      step();
      check("d0 k data", 8'(d0), 8'h0);
      step();
      check("d0 k1 data", 8'(d0), 8'h0);
      check("d0 k1 chg", 8'(c0), 8'h0);
      step();
      check("d0 k2 data", 8'(d0), 8'h5);
      check("d0 k2 rise", 8'(r0), 8'h5);
      check("d0 k2 fall", 8'(f0), 8'h0);
      check("d0 k2 chg", 8'(c0), 8'h1);
      step();
      check("d0 k3 data", 8'(d0), 8'h5);
      check("d0 k3 rise", 8'(r0), 8'h0);
      check("d0 k3 chg", 8'(c0), 8'h0);

      // S=3 F=4: a 3-cycle glitch is rejected
      i1 = 4'b0001;
      step();
      step();
      step();
      i1 = 4'b0000;
      for (int n = 0; n < 10; n++) begin
         check("glitch data", 8'(d1), 8'h0);
         check("glitch rise", 8'(r1), 8'h0);
         step();
      end
      // Stable high: o_data at edge k+6
      i1 = 4'b0001;
      for (int n = 0; n < 6; n++) begin
         step();
         check("f4 pre data", 8'(d1), 8'h0);
      end
      step();
      check("f4 k6 data", 8'(d1), 8'h1);
      check("f4 k6 rise", 8'(r1), 8'h1);
      check("f4 k6 chg", 8'(c1), 8'h1);
      step();
      check("f4 k7 rise", 8'(r1), 8'h0);

      // Reset mid-filter: clean start, bit 2 reaches count 2, then one reset cycle
      i1 = 4'b0000;
      rst1 = 1'b1;
      step();
      rst1 = 1'b0;
      check("mf rst data", 8'(d1), 8'h0);
      i1 = 4'b0100;
      for (int n = 0; n < 5; n++) step();
      rst1 = 1'b1;
      step();
      rst1 = 1'b0;
      check("mf during rst", 8'(d1), 8'h0);
      for (int n = 0; n < 6; n++) begin
         step();
         check("mf post data", 8'(d1), 8'h0);
      end
      step();
      check("mf done data", 8'(d1), 8'h4);
      check("mf done rise", 8'(r1), 8'h4);

      // F=2: bit 1 toggles every 8 cycles, pulses must alternate and never abut
      rises = 0;
      falls = 0;
      prev_pulse = 1'b0;
      last_was_rise = 1'b0;
      order_ok = 1'b1;
      for (int t = 0; t < 52; t++) begin
         if (t < 48 && (t % 8) == 0) i4[1] = ~i4[1];
         step();
         check("alt both", 8'(r4[1] & f4[1]), 8'h0);
         cur_pulse = r4[1] | f4[1];
         check("alt consec", 8'(prev_pulse & cur_pulse), 8'h0);
         if (r4[1]) begin
            if (rises + falls > 0 && last_was_rise) order_ok = 1'b0;
            rises++;
            last_was_rise = 1'b1;
         end
         if (f4[1]) begin
            if (rises + falls == 0 || !last_was_rise) order_ok = 1'b0;
            falls++;
            last_was_rise = 1'b0;
         end
         prev_pulse = cur_pulse;
      end
      check("alt rises", 8'(rises), 8'd3);
      check("alt falls", 8'(falls), 8'd3);
      check("alt order", 8'(order_ok), 8'h1);
      check("alt other bits", 8'({r4[3:2], r4[0], f4[3:2], f4[0]}), 8'h0);

      // S=8: latency exactly 8 edges after capture
      i3 = 4'b1010;
      for (int n = 0; n < 8; n++) begin
         step();
         check("s8 pre data", 8'(d3), 8'h0);
      end
      step();
      check("s8 k8 data", 8'(d3), 8'ha);
      check("s8 k8 rise", 8'(r3), 8'ha);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
